// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: port identifiers, the
// in-flight tag record and a helper that decodes a tag for a given port.
package mem_arb_pkg;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_MEM   = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
    logic write;
  } mem_arb_tag_t;

  localparam int TAG_W = $bits(mem_arb_tag_t);

  function automatic logic rsp_hit(input mem_arb_tag_t tag, input logic port);
    return tag.valid && (tag.owner == port);
  endfunction

endpackage

// File: rtl/mem_arb_tagpipe.sv
// Fixed-depth shift register of in-flight access tags; the tail stage lines
// up with RAM read data. i_clear drops every tag in the same cycle.
import mem_arb_pkg::*;

module mem_arb_tagpipe #(
  parameter int DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_clear,
  input  mem_arb_tag_t       i_tag,
  output mem_arb_tag_t       o_tail,
  output logic [DEPTH-1:0]   o_valids
);

  logic [DEPTH-1:0][TAG_W-1:0] r_stages;

  // Stage 0 holds the access issued this cycle; index DEPTH-1 is the oldest.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_stages <= '0;
    end else begin
      r_stages <= {r_stages[DEPTH-2:0], i_tag};
    end
  end

  assign o_tail = r_stages[DEPTH-1];

  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    mem_arb_tag_t w_stage;
    assign w_stage     = r_stages[g];
    assign o_valids[g] = w_stage.valid;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported RAM between instruction fetch (port 0) and the Mem
// stage (port 1). Define MEM_ARB_RR_EN for strict round-robin instead of
// port-1 priority with a MAX_STREAK anti-starvation limit.
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RAM_LAT    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_mem_ram_load,
  input  logic              i_p0_valid,
  output logic              o_p0_ready,
  input  logic              i_p0_write,
  input  logic [ADDR_W-1:0] i_p0_addr,
  input  logic [DATA_W-1:0] i_p0_wdata,
  output logic              o_p0_rsp_valid,
  output logic [DATA_W-1:0] o_p0_rsp_rdata,
  input  logic              i_p1_valid,
  output logic              o_p1_ready,
  input  logic              i_p1_write,
  input  logic [ADDR_W-1:0] i_p1_addr,
  input  logic [DATA_W-1:0] i_p1_wdata,
  output logic              o_p1_rsp_valid,
  output logic [DATA_W-1:0] o_p1_rsp_rdata,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_arb_busy
);

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [DATA_W-1:0] w_rdata;
  mem_arb_tag_t      w_tag;
  mem_arb_tag_t      w_tail;
  logic [RAM_LAT:0]  w_valids;

`ifdef MEM_ARB_RR_EN
  logic r_last_grant;

  // Contended cycles go to the port that did not win last time.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (i_reset || i_mem_ram_load) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end else if (i_p0_valid && i_p1_valid) begin
      w_gnt0 = (r_last_grant == PORT_MEM);
      w_gnt1 = (r_last_grant == PORT_FETCH);
    end else begin
      w_gnt0 = i_p0_valid;
      w_gnt1 = i_p1_valid;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_last_grant <= PORT_FETCH;
    end else if (w_gnt0) begin
      r_last_grant <= PORT_FETCH;
    end else if (w_gnt1) begin
      r_last_grant <= PORT_MEM;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end
`else
  localparam int STREAK_W = $clog2(MAX_STREAK + 1);

  logic [STREAK_W-1:0] r_streak;
  logic                w_force0;

  // Port 1 wins unless fetch has already waited out MAX_STREAK port-1 grants.
  always_comb begin
    w_gnt0   = 1'b0;
    w_gnt1   = 1'b0;
    w_force0 = (r_streak == STREAK_W'(MAX_STREAK)) && i_p0_valid;
    if (i_reset || i_mem_ram_load) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end else if (i_p1_valid && !w_force0) begin
      w_gnt1 = 1'b1;
    end else begin
      w_gnt0 = i_p0_valid;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_streak <= '0;
    end else if (!i_p0_valid || w_gnt0) begin
      r_streak <= '0;
    end else if (w_gnt1 && (r_streak != STREAK_W'(MAX_STREAK))) begin
      r_streak <= r_streak + STREAK_W'(1);
    end else begin
      r_streak <= r_streak;
    end
  end
`endif

  assign o_p0_ready  = w_gnt0;
  assign o_p1_ready  = w_gnt1;
  assign w_sel_we    = w_gnt1 ? i_p1_write : i_p0_write;
  assign w_sel_addr  = w_gnt1 ? i_p1_addr  : i_p0_addr;
  assign w_sel_wdata = w_gnt1 ? i_p1_wdata : i_p0_wdata;

  always_comb begin
    w_tag       = '0;
    w_tag.valid = w_gnt0 || w_gnt1;
    w_tag.owner = w_gnt1 ? PORT_MEM : PORT_FETCH;
    w_tag.write = w_sel_we;
  end

  // Idle cycles drive zeros so the RAM bus is quiet between accesses.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_ram_en    <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_wdata <= '0;
    end else if (w_gnt0 || w_gnt1) begin
      o_ram_en    <= 1'b1;
      o_ram_we    <= w_sel_we;
      o_ram_addr  <= w_sel_addr;
      o_ram_wdata <= w_sel_wdata;
    end else begin
      o_ram_en    <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_wdata <= '0;
    end
  end

  mem_arb_tagpipe #(
    .DEPTH (RAM_LAT + 1)
  ) u_tagpipe (
    .i_clk    (i_clock),
    .i_clear  (i_reset),
    .i_tag    (w_tag),
    .o_tail   (w_tail),
    .o_valids (w_valids)
  );

  // Store acks carry zero data; the tail tag is aligned with i_ram_rdata.
  assign w_rdata        = (w_tail.valid && !w_tail.write) ? i_ram_rdata : '0;
  assign o_p0_rsp_valid = rsp_hit(w_tail, PORT_FETCH);
  assign o_p1_rsp_valid = rsp_hit(w_tail, PORT_MEM);
  assign o_p0_rsp_rdata = o_p0_rsp_valid ? w_rdata : '0;
  assign o_p1_rsp_rdata = o_p1_rsp_valid ? w_rdata : '0;
  assign o_arb_busy     = |w_valids;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RAM_LAT=1 and one
// with RAM_LAT=3 share the request inputs, each with its own RAM model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        ram_load;
  logic        p0_valid, p0_write, p1_valid, p1_write;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        init_we;
  logic [7:0]  init_addr;
  logic [31:0] init_data;

  logic        a_p0_ready, a_p1_ready, a_p0_rsp_valid, a_p1_rsp_valid;
  logic [31:0] a_p0_rsp_rdata, a_p1_rsp_rdata;
  logic        a_ram_en, a_ram_we, a_busy;
  logic [31:0] a_ram_addr, a_ram_wdata, a_rdata;

  logic        b_p0_ready, b_p1_ready, b_p0_rsp_valid, b_p1_rsp_valid;
  logic [31:0] b_p0_rsp_rdata, b_p1_rsp_rdata;
  logic        b_ram_en, b_ram_we, b_busy;
  logic [31:0] b_ram_addr, b_ram_wdata, b_rdata, b_pipe0, b_pipe1;

  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];

  int checks = 0;
  int errors = 0;
  logic [9:0] gpat;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1), .MAX_STREAK(4)) dut (
    .i_clock(clk), .i_reset(rst), .i_mem_ram_load(ram_load),
    .i_p0_valid(p0_valid), .o_p0_ready(a_p0_ready), .i_p0_write(p0_write),
    .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
    .o_p0_rsp_valid(a_p0_rsp_valid), .o_p0_rsp_rdata(a_p0_rsp_rdata),
    .i_p1_valid(p1_valid), .o_p1_ready(a_p1_ready), .i_p1_write(p1_write),
    .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
    .o_p1_rsp_valid(a_p1_rsp_valid), .o_p1_rsp_rdata(a_p1_rsp_rdata),
    .o_ram_en(a_ram_en), .o_ram_we(a_ram_we), .o_ram_addr(a_ram_addr),
    .o_ram_wdata(a_ram_wdata), .i_ram_rdata(a_rdata), .o_arb_busy(a_busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(3), .MAX_STREAK(4)) dut3 (
    .i_clock(clk), .i_reset(rst), .i_mem_ram_load(ram_load),
    .i_p0_valid(p0_valid), .o_p0_ready(b_p0_ready), .i_p0_write(p0_write),
    .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
    .o_p0_rsp_valid(b_p0_rsp_valid), .o_p0_rsp_rdata(b_p0_rsp_rdata),
    .i_p1_valid(p1_valid), .o_p1_ready(b_p1_ready), .i_p1_write(p1_write),
    .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
    .o_p1_rsp_valid(b_p1_rsp_valid), .o_p1_rsp_rdata(b_p1_rsp_rdata),
    .o_ram_en(b_ram_en), .o_ram_we(b_ram_we), .o_ram_addr(b_ram_addr),
    .o_ram_wdata(b_ram_wdata), .i_ram_rdata(b_rdata), .o_arb_busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: 1-cycle and 3-cycle read latency, plus a preload port.
  always @(posedge clk) begin
    if (init_we) begin
      mem1[init_addr] <= init_data;
      mem3[init_addr] <= init_data;
    end else begin
      if (a_ram_en && a_ram_we) mem1[a_ram_addr[7:0]] <= a_ram_wdata;
      if (b_ram_en && b_ram_we) mem3[b_ram_addr[7:0]] <= b_ram_wdata;
    end
    if (a_ram_en && !a_ram_we) a_rdata <= mem1[a_ram_addr[7:0]];
    if (b_ram_en && !b_ram_we) b_pipe0 <= mem3[b_ram_addr[7:0]];
    b_pipe1 <= b_pipe0;
    b_rdata <= b_pipe1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef MEM_ARB_RR_EN
    gpat = 10'b0101010101;
`else
    gpat = 10'b0111101111;
`endif
    rst = 1'b1; ram_load = 1'b0; init_we = 1'b0; init_addr = 8'h00; init_data = 32'h0;
    p0_valid = 1'b0; p0_write = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_valid = 1'b0; p1_write = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
    repeat (2) next_cycle();

    // Reset state
    rst = 1'b0; #1;
    chk("rst_a_ctl", {a_p0_ready, a_p1_ready, a_p0_rsp_valid, a_p1_rsp_valid, a_ram_en, a_ram_we, a_busy}, 64'h0);
    chk("rst_a_bus", {a_ram_addr, a_ram_wdata}, 64'h0);
    chk("rst_a_rsp", {a_p0_rsp_rdata, a_p1_rsp_rdata}, 64'h0);
    chk("rst_b_ctl", {b_p0_rsp_valid, b_p1_rsp_valid, b_ram_en, b_ram_we, b_busy}, 64'h0);
    next_cycle();

    // Preload RAM models while the arbiter is held off
    ram_load = 1'b1;
    for (int i = 0; i < 9; i++) begin
      init_we   = 1'b1;
      init_addr = (i == 0) ? 8'h10 : 8'h40 + 8'(i - 1);
      init_data = (i == 0) ? 32'hDEADBEEF : 32'hA000_0000 + 32'(i - 1);
      next_cycle();
    end
    init_we = 1'b0; ram_load = 1'b0;

    // Test 1: lone port-1 load
    p1_valid = 1'b1; p1_write = 1'b0; p1_addr = 32'h10; #1;
    chk("t1_ready", {a_p0_ready, a_p1_ready}, 64'h1);
    next_cycle();
    p1_valid = 1'b0; #1;
    chk("t1_issue", {a_ram_en, a_ram_we, a_busy, a_p1_rsp_valid}, 64'b1010);
    chk("t1_addr", a_ram_addr, 64'h10);
    next_cycle(); #1;
    chk("t1_rsp_v", {a_p0_rsp_valid, a_p1_rsp_valid}, 64'h1);
    chk("t1_rsp_d", a_p1_rsp_rdata, 64'hDEADBEEF);
    next_cycle(); #1;
    chk("t1_idle", {a_p1_rsp_valid, a_busy}, 64'h0);
    next_cycle();

    // Test 3: port-1 store then port-0 load of the same word
    p1_valid = 1'b1; p1_write = 1'b1; p1_addr = 32'h20; p1_wdata = 32'h55; #1;
    chk("t3_p1_ready", a_p1_ready, 64'h1);
    next_cycle();
    p1_valid = 1'b0; p1_write = 1'b0;
    p0_valid = 1'b1; p0_write = 1'b0; p0_addr = 32'h20; #1;
    chk("t3_p0_ready", a_p0_ready, 64'h1);
    chk("t3_store", {a_ram_en, a_ram_we}, 64'b11);
    chk("t3_store_bus", {a_ram_addr, a_ram_wdata}, {32'h20, 32'h55});
    next_cycle();
    p0_valid = 1'b0; #1;
    chk("t3_ack_v", {a_p0_rsp_valid, a_p1_rsp_valid}, 64'h1);
    chk("t3_ack_d", a_p1_rsp_rdata, 64'h0);
    next_cycle(); #1;
    chk("t3_load_v", {a_p0_rsp_valid, a_p1_rsp_valid}, 64'b10);
    chk("t3_load_d", a_p0_rsp_rdata, 64'h55);
    next_cycle();

    // Test 4: RAM load blocks both ports
    ram_load = 1'b1;
    p0_valid = 1'b1; p0_write = 1'b0; p0_addr = 32'h10;
    p1_valid = 1'b1; p1_write = 1'b0; p1_addr = 32'h20;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_blocked", {a_p0_ready, a_p1_ready, a_ram_en}, 64'h0);
      next_cycle();
    end
    ram_load = 1'b0;

    // Test 2: continuous contention, starting on the release cycle
    for (int k = 0; k < 12; k++) begin
      if (k == 10) begin
        p0_valid = 1'b0; p1_valid = 1'b0;
      end
      #1;
      if (k < 10) begin
        chk("t2_p1_grant", a_p1_ready, 64'(gpat[k]));
        chk("t2_p0_grant", a_p0_ready, 64'(!gpat[k]));
      end
      if (k >= 2) begin
        chk("t2_rsp_owner", {a_p0_rsp_valid, a_p1_rsp_valid}, gpat[k-2] ? 64'b01 : 64'b10);
        chk("t2_rsp_data", gpat[k-2] ? a_p1_rsp_rdata : a_p0_rsp_rdata,
            gpat[k-2] ? 64'h55 : 64'hDEADBEEF);
      end
      next_cycle();
    end

    // Test 5: reset while a load is in flight
    p1_valid = 1'b1; p1_write = 1'b0; p1_addr = 32'h10; #1;
    chk("t5_ready", a_p1_ready, 64'h1);
    next_cycle();
    p1_valid = 1'b0; rst = 1'b1; #1;
    chk("t5_issue", a_ram_en, 64'h1);
    next_cycle();
    rst = 1'b0; #1;
    chk("t5_a_ctl", {a_p0_ready, a_p1_ready, a_p0_rsp_valid, a_p1_rsp_valid, a_ram_en, a_ram_we, a_busy}, 64'h0);
    chk("t5_a_bus", {a_ram_addr, a_ram_wdata}, 64'h0);
    chk("t5_b_ctl", {b_p0_rsp_valid, b_p1_rsp_valid, b_ram_en, b_busy}, 64'h0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t5_no_rsp", {a_p0_rsp_valid, a_p1_rsp_valid, b_p0_rsp_valid, b_p1_rsp_valid}, 64'h0);
      next_cycle();
    end

    // Test 6: 8 back-to-back alternating loads on the RAM_LAT=3 instance
    for (int c = 0; c < 13; c++) begin
      if (c < 8) begin
        p1_valid = (c % 2 == 0);
        p0_valid = (c % 2 == 1);
        p0_addr  = 32'h40 + 32'(c);
        p1_addr  = 32'h40 + 32'(c);
      end else begin
        p0_valid = 1'b0; p1_valid = 1'b0;
      end
      #1;
      if (c < 8) begin
        chk("t6_ready", {b_p0_ready, b_p1_ready}, (c % 2 == 0) ? 64'b01 : 64'b10);
      end
      if (c >= 4 && c < 12) begin
        chk("t6_rsp_owner", {b_p0_rsp_valid, b_p1_rsp_valid}, ((c - 4) % 2 == 0) ? 64'b01 : 64'b10);
        chk("t6_rsp_data", ((c - 4) % 2 == 0) ? b_p1_rsp_rdata : b_p0_rsp_rdata,
            64'hA000_0000 + 64'(c - 4));
      end
      if (c == 11) chk("t6_busy_tail", b_busy, 64'h1);
      if (c == 12) chk("t6_busy_done", {b_busy, b_p0_rsp_valid, b_p1_rsp_valid}, 64'h0);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
